// File: rtl/alu_pkg.sv
// Shared types and defaults for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_OR  = 2'd2,
    ALU_AND = 2'd3
  } alu_op_e;

  // True for the two ops that go through the shared adder.
  function automatic logic alu_is_arith(alu_op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder with carry-in, shared by ADD and SUB (caller supplies ~b and cin=1 for SUB).
module alu_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum      = full_sum[WIDTH-1:0];
    cout     = full_sum[WIDTH];
    // Same-sign inputs producing a different-sign sum; with b already inverted
    // for SUB this is exactly the subtract overflow rule as well.
    overflow = (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu.sv
// 4-function ALU with combinational result/flags and a one-cycle registered result.
// Define ALU_FLAGS_REG_EN to also register zero/carry/overflow.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q,
`ifdef ALU_FLAGS_REG_EN
  output logic             zero_q,
  output logic             carry_q,
  output logic             overflow_q,
`endif
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  alu_op_e          op;
  logic             is_sub;
  logic [WIDTH-1:0] addsub_b;
  logic [WIDTH-1:0] addsub_sum;
  logic             addsub_cout;
  logic             addsub_ovf;

  assign op       = alu_op_e'(func);
  assign is_sub   = (op == ALU_SUB);
  assign addsub_b = is_sub ? ~b : b;

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a        (a),
    .b        (addsub_b),
    .cin      (is_sub),
    .sum      (addsub_sum),
    .cout     (addsub_cout),
    .overflow (addsub_ovf)
  );

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = addsub_sum;
      ALU_SUB: result = addsub_sum;
      ALU_OR:  result = a | b;
      ALU_AND: result = a & b;
      default: result = '0;
    endcase
  end

  // Arithmetic flags are forced low for the logic ops.
  always_comb begin
    zero     = (result == '0);
    carry    = alu_is_arith(op) ? addsub_cout : 1'b0;
    overflow = alu_is_arith(op) ? addsub_ovf : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result;
    end
  end

`ifdef ALU_FLAGS_REG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      zero_q     <= zero;
      carry_q    <= carry;
      overflow_q <= overflow;
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu.
module tb_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  func;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic [31:0] result_q;
  logic        zero;
  logic        carry;
  logic        overflow;
`ifdef ALU_FLAGS_REG_EN
  logic        zero_q;
  logic        carry_q;
  logic        overflow_q;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu #(
    .WIDTH (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .func     (func),
    .a        (a),
    .b        (b),
    .result   (result),
    .result_q (result_q),
`ifdef ALU_FLAGS_REG_EN
    .zero_q     (zero_q),
    .carry_q    (carry_q),
    .overflow_q (overflow_q),
`endif
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs away from the edge, then let combinational outputs settle.
  task automatic apply(input logic [1:0] f, input logic [31:0] va, input logic [31:0] vb);
    func = f;
    a    = va;
    b    = vb;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic z, input logic c, input logic o);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, z});
    check({tag, "_carry"}, {31'b0, carry}, {31'b0, c});
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, o});
  endtask

  initial begin
    reset = 1'b1;
    func  = 2'd0;
    a     = 32'd2;
    b     = 32'd3;
    tick();
    check("reset_result_q", result_q, 32'h0);
    check("reset_comb_result", result, 32'd5);
`ifdef ALU_FLAGS_REG_EN
    check("reset_flags_q", {29'b0, zero_q, carry_q, overflow_q}, 32'h0);
`endif
    reset = 1'b0;

    // ADD 2+3
    apply(2'd0, 32'd2, 32'd3);
    check("add_2_3", result, 32'd5);
    check_flags("add_2_3", 1'b0, 1'b0, 1'b0);
    tick();
    check("add_2_3_q", result_q, 32'd5);

    // Operand change: combinational moves now, register one edge later
    apply(2'd0, 32'd5, 32'd3);
    check("add_5_3", result, 32'd8);
    check("add_5_3_q_old", result_q, 32'd5);
    tick();
    check("add_5_3_q", result_q, 32'd8);

    apply(2'd3, 32'd1, 32'd3);
    check("and_1_3", result, 32'd1);
    apply(2'd2, 32'd1, 32'd2);
    check("or_1_2", result, 32'd3);

    // Logic ops must not report adder carry/overflow
    apply(2'd2, 32'hFFFF_FFFF, 32'd1);
    check("or_all_ones", result, 32'hFFFF_FFFF);
    check_flags("or_all_ones", 1'b0, 1'b0, 1'b0);
    apply(2'd3, 32'h0000_00F0, 32'h0000_000F);
    check("and_disjoint", result, 32'h0);
    check_flags("and_disjoint", 1'b1, 1'b0, 1'b0);
    apply(2'd3, 32'h8000_0000, 32'h8000_0000);
    check_flags("and_sign", 1'b0, 1'b0, 1'b0);

    // SUB with borrow, then equal operands
    apply(2'd1, 32'd3, 32'd5);
    check("sub_3_5", result, 32'hFFFF_FFFE);
    check_flags("sub_3_5", 1'b0, 1'b0, 1'b0);
    apply(2'd1, 32'd5, 32'd5);
    check("sub_5_5", result, 32'h0);
    check_flags("sub_5_5", 1'b1, 1'b1, 1'b0);
    tick();
    check("sub_5_5_q", result_q, 32'h0);

    // Signed overflow and unsigned wrap
    apply(2'd0, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf", result, 32'h8000_0000);
    check_flags("add_ovf", 1'b0, 1'b0, 1'b1);
    apply(2'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap", result, 32'h0);
    check_flags("add_wrap", 1'b1, 1'b1, 1'b0);
    apply(2'd0, 32'h8000_0000, 32'h8000_0000);
    check("add_neg_ovf", result, 32'h0);
    check_flags("add_neg_ovf", 1'b1, 1'b1, 1'b1);
    apply(2'd1, 32'h8000_0000, 32'd1);
    check("sub_ovf", result, 32'h7FFF_FFFF);
    check_flags("sub_ovf", 1'b0, 1'b1, 1'b1);
    apply(2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    check("sub_pos_ovf", result, 32'h8000_0000);
    check_flags("sub_pos_ovf", 1'b0, 1'b0, 1'b1);
    apply(2'd1, 32'h8000_0000, 32'd1);
    tick();
    check("sub_ovf_q", result_q, 32'h7FFF_FFFF);
`ifdef ALU_FLAGS_REG_EN
    check("sub_ovf_flags_q", {29'b0, zero_q, carry_q, overflow_q}, 32'h3);
`endif

    // Reset mid-operation: register clears, combinational path keeps going
    apply(2'd0, 32'd2, 32'd3);
    tick();
    check("pre_reset_q", result_q, 32'd5);
    reset = 1'b1;
    tick();
    check("mid_reset_q", result_q, 32'h0);
    check("mid_reset_comb", result, 32'd5);
`ifdef ALU_FLAGS_REG_EN
    check("mid_reset_flags_q", {29'b0, zero_q, carry_q, overflow_q}, 32'h0);
`endif
    reset = 1'b0;
    tick();
    check("post_reset_q", result_q, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
